imem_program_loader: RTL and testbench
======================================

Name: imem_program_loader

Overview:
- Upstream neighbour of the pipelined RV32 core.
- Receives a framed byte stream from the board's serial receiver and assembles little-endian 32-bit instruction words.
- Writes the words into instruction memory through a write port.
- Holds the core in reset (cpu_start low) until a complete program has been loaded, then releases it.
- A later load_req pulse re-arms loading, which puts the core back into reset.

Parameters:
- ADDR_W, 8, word-address width of instruction memory; depth is 2**ADDR_W words.
- TIMEOUT, 1000000, maximum idle clk cycles allowed between bytes inside a frame.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  loader can accept a byte; a transfer occurs when rx_valid and rx_ready are both high on a clk edge.
- load_req  in  1  single-cycle request to (re)start loading.
- imem_we  out  1  instruction memory write strobe, one cycle per word.
- imem_addr  out  ADDR_W  word index; byte address = imem_addr*4.
- imem_wdata  out  32  instruction word.
- cpu_start  out  1  drives the core's start input; low holds the core in reset.
- busy  out  1  high in LEN0, LEN1 and DATA.
- error  out  1  high in ERR.
- words_loaded  out  ADDR_W+1  words written in the current or most recent frame.

Behaviour:
- Frame format: LEN_LO, LEN_HI (N = 16-bit word count), then N*4 bytes, least-significant byte of each word first.
- States: LEN0, LEN1, DATA, RUN, ERR.
- Reset (rst low, asynchronous) forces: state LEN0; cpu_start=0; imem_we=0; imem_addr=0; imem_wdata=0; words_loaded=0; error=0; byte index=0; gap counter=0.
- rx_ready=1 in LEN0, LEN1 and DATA; 0 in RUN and ERR. Bytes presented while rx_ready=0 are not consumed.
- LEN0: on accept, latch the low count byte and go to LEN1.
- LEN1: on accept, latch the high count byte.
  - N=0: go straight to RUN.
  - N>2**ADDR_W: go to ERR.
  - Otherwise: go to DATA with word index 0.
- DATA byte assembly: shift register, new byte enters bits [31:24] and the rest shift right, so byte 0 ends up in [7:0].
- On the 4th accepted byte of a word, the next cycle has imem_we=1, imem_wdata=assembled word, imem_addr=word index. The index and words_loaded increment in that same cycle.
- Back-to-back bytes are accepted every cycle; rx_ready stays high in DATA, and the write register never stalls intake.
- Last word: the state moves to RUN in the cycle of its imem_we pulse, and cpu_start rises on the following cycle. This guarantees the last write completes before the core leaves reset.
- RUN: cpu_start=1 and held.
- Gap timeout:
  - The gap counter counts cycles without an accepted byte in LEN1 and DATA, and clears on each accepted byte.
  - It does not count in LEN0, so waiting for a frame never times out.
  - When the counter reaches TIMEOUT, go to ERR.
- ERR: error=1, cpu_start=0. A partially written memory is left as is.
- load_req in any state:
  - Next state LEN0; cpu_start=0 next cycle.
  - error, words_loaded, byte index, word index and gap counter are all cleared.
  - Any partial word is discarded.
- load_req has priority over a simultaneous byte accept; that byte is dropped.
- imem_addr wraps only at 2**ADDR_W. This is unreachable, because N is bounded at LEN1.

Decomposition:
- Shared package (loader_pkg):
  - state enum {LEN0, LEN1, DATA, RUN, ERR};
  - frame header length constant, 2 bytes;
  - bytes-per-word constant, 4.
- One sub-module, loader_word_pack:
  - byte shift register plus 2-bit byte index;
  - outputs word and word_done;
  - has a clear input driven by load_req.
- The FSM, counters and write register stay in imem_program_loader.

Test Plan:
- Reset mid-DATA after 5 bytes, then release → all outputs at reset values, state LEN0, the next frame loads from addr 0.
- Frame 02 00 13 05 10 00 93 05 20 00, bytes back-to-back →
  - writes addr0=0x00100513 and addr1=0x00200593 on consecutive pulses;
  - cpu_start rises one cycle after the second pulse;
  - words_loaded=2.
- Frame 00 00 → no imem_we; cpu_start=1 two cycles after the LEN_HI accept.
- Count 0x0101 with ADDR_W=8 → ERR, error=1, cpu_start=0, rx_ready=0; a load_req then returns to LEN0 with error=0.
- Timeout (TIMEOUT=16): 2 bytes of a word, then rx_valid=0 for 16 cycles → ERR, no imem_we issued.
- load_req in RUN with rx_valid asserted in the same cycle → cpu_start=0 next cycle; that byte is not consumed; the following frame of 1 word writes addr 0.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and framing constants for the instruction-memory program loader.
package loader_pkg;

    typedef enum logic [2:0] {
        ST_LEN0,
        ST_LEN1,
        ST_DATA,
        ST_RUN,
        ST_ERR
    } state_e;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/loader_word_pack.sv
// Assembles little-endian 32-bit words from a byte stream; byte 0 lands in [7:0].
module loader_word_pack
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        byte_vld_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_done_o
);

    logic [31:0] shreg_q;
    logic [1:0]  idx_q;

    // The completed word includes the byte arriving this cycle so the write
    // register can capture it on the same edge.
    assign word_o      = {byte_i, shreg_q[31:8]};
    assign word_done_o = byte_vld_i && (idx_q == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg_q <= '0;
            idx_q   <= '0;
        end else if (clr_i) begin
            shreg_q <= '0;
            idx_q   <= '0;
        end else if (byte_vld_i) begin
            shreg_q <= word_o;
            idx_q   <= idx_q + 2'd1;
        end
    end

endmodule

// File: rtl/imem_program_loader.sv
// Loads a length-prefixed program into instruction memory and releases the core once done.
module imem_program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              load_req,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_start,
    output logic              busy,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int              GAP_W     = $clog2(TIMEOUT + 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(TIMEOUT - 1);
    localparam logic [16:0]     MAX_WORDS = 17'(2 ** ADDR_W);

    state_e            state_q;
    logic [7:0]        len_lo_q;
    logic [15:0]       len_q;
    logic [ADDR_W-1:0] word_idx_q;
    logic [ADDR_W-1:0] imem_addr_q;
    logic [31:0]       wdata_q;
    logic              we_q;
    logic              cpu_start_q;
    logic [ADDR_W:0]   words_q;
    logic [GAP_W-1:0]  gap_q;

    logic        accept;
    logic        word_vld;
    logic [31:0] word;
    logic        word_done;
    logic [15:0] len_d;
    logic        too_long;
    logic        last_word;

    assign rx_ready  = (state_q == ST_LEN0) || (state_q == ST_LEN1) || (state_q == ST_DATA);
    assign busy      = rx_ready;
    assign error     = (state_q == ST_ERR);
    // A reload request wins over a byte offered in the same cycle.
    assign accept    = rx_valid && rx_ready && !load_req;
    assign word_vld  = accept && (state_q == ST_DATA);
    assign len_d     = {rx_data, len_lo_q};
    assign too_long  = {1'b0, len_d} > MAX_WORDS;
    assign last_word = (16'(words_q) + 16'd1) == len_q;

    loader_word_pack u_pack (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (load_req),
        .byte_vld_i  (word_vld),
        .byte_i      (rx_data),
        .word_o      (word),
        .word_done_o (word_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_LEN0;
            len_lo_q    <= '0;
            len_q       <= '0;
            word_idx_q  <= '0;
            imem_addr_q <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            cpu_start_q <= 1'b0;
            words_q     <= '0;
            gap_q       <= '0;
        end else begin
            we_q        <= word_done;
            cpu_start_q <= (state_q == ST_RUN) && !load_req;

            if (word_done) begin
                wdata_q     <= word;
                imem_addr_q <= word_idx_q;
                word_idx_q  <= word_idx_q + ADDR_W'(1);
                words_q     <= words_q + (ADDR_W + 1)'(1);
            end

            if (load_req) begin
                state_q    <= ST_LEN0;
                word_idx_q <= '0;
                words_q    <= '0;
                gap_q      <= '0;
            end else begin
                case (state_q)
                    ST_LEN0: begin
                        gap_q <= '0;
                        if (accept) begin
                            len_lo_q <= rx_data;
                            state_q  <= ST_LEN1;
                        end
                    end
                    ST_LEN1: begin
                        if (accept) begin
                            gap_q      <= '0;
                            len_q      <= len_d;
                            word_idx_q <= '0;
                            words_q    <= '0;
                            if (len_d == 16'd0)  state_q <= ST_RUN;
                            else if (too_long)   state_q <= ST_ERR;
                            else                 state_q <= ST_DATA;
                        end else if (gap_q == GAP_LAST) begin
                            gap_q   <= '0;
                            state_q <= ST_ERR;
                        end else begin
                            gap_q <= gap_q + GAP_W'(1);
                        end
                    end
                    ST_DATA: begin
                        // Leaving on the last word's write edge lets cpu_start trail the write by one cycle.
                        if (accept) begin
                            gap_q <= '0;
                            if (word_done && last_word) state_q <= ST_RUN;
                        end else if (gap_q == GAP_LAST) begin
                            gap_q   <= '0;
                            state_q <= ST_ERR;
                        end else begin
                            gap_q <= gap_q + GAP_W'(1);
                        end
                    end
                    default: gap_q <= '0;
                endcase
            end
        end
    end

    assign imem_we      = we_q;
    assign imem_addr    = imem_addr_q;
    assign imem_wdata   = wdata_q;
    assign cpu_start    = cpu_start_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed bench for imem_program_loader with a byte-counting reference model checked every cycle.
module tb_imem_program_loader;
    import loader_pkg::*;

    localparam int AW  = 8;
    localparam int TMO = 16;
    localparam int P_HDR = 0, P_DATA = 1, P_RUN = 2, P_ERR = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          load_req;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_start;
    logic          busy;
    logic          error;
    logic [AW:0]   words_loaded;

    imem_program_loader #(.ADDR_W(AW), .TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .load_req     (load_req),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_start    (cpu_start),
        .busy         (busy),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit chk_on = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: frame-level byte counting
    int         m_phase, m_hdr, m_len, m_bytes, m_words, m_idle;
    logic [7:0] m_buf [4];
    logic       m_we, m_start;
    logic [31:0] m_addr, m_wdata;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase = P_HDR; m_hdr = 0; m_len = 0; m_bytes = 0; m_words = 0; m_idle = 0;
            m_we = 0; m_start = 0; m_addr = 0; m_wdata = 0;
        end else begin
            bit acc, nwe, nstart;
            acc    = rx_valid && (m_phase == P_HDR || m_phase == P_DATA) && !load_req;
            nwe    = 0;
            nstart = (m_phase == P_RUN) && !load_req;
            if (load_req) begin
                m_phase = P_HDR; m_hdr = 0; m_bytes = 0; m_words = 0; m_idle = 0;
            end else if (m_phase == P_HDR) begin
                if (acc) begin
                    m_idle = 0;
                    if (m_hdr < HDR_BYTES - 1) begin
                        m_len = int'(rx_data); m_hdr++;
                    end else begin
                        m_len += 256 * int'(rx_data); m_hdr = 0;
                        m_bytes = 0; m_words = 0;
                        if (m_len == 0)        m_phase = P_RUN;
                        else if (m_len > 256)  m_phase = P_ERR;
                        else                   m_phase = P_DATA;
                    end
                end else if (m_hdr > 0) begin
                    m_idle++;
                    if (m_idle >= TMO) m_phase = P_ERR;
                end
            end else if (m_phase == P_DATA) begin
                if (acc) begin
                    m_idle = 0;
                    m_buf[m_bytes % BYTES_PER_WORD] = rx_data;
                    m_bytes++;
                    if (m_bytes % BYTES_PER_WORD == 0) begin
                        nwe = 1;
                        m_wdata = {m_buf[3], m_buf[2], m_buf[1], m_buf[0]};
                        m_addr = m_words;
                        m_words++;
                        if (m_words == m_len) m_phase = P_RUN;
                    end
                end else begin
                    m_idle++;
                    if (m_idle >= TMO) m_phase = P_ERR;
                end
            end
            m_we = nwe;
            m_start = nstart;
        end
    end

    int  wr_addr [$];
    int  wr_data [$];
    int  wr_cyc  [$];
    int  start_cyc = -1;
    bit  start_prev = 1'b0;

    always @(negedge clk) begin
        if (chk_on) begin
            bit live;
            live = (m_phase == P_HDR || m_phase == P_DATA);
            chk("rx_ready",     {31'd0, rx_ready},  {31'd0, live});
            chk("busy",         {31'd0, busy},      {31'd0, live});
            chk("error",        {31'd0, error},     {31'd0, m_phase == P_ERR});
            chk("cpu_start",    {31'd0, cpu_start}, {31'd0, m_start});
            chk("imem_we",      {31'd0, imem_we},   {31'd0, m_we});
            chk("imem_addr",    32'(imem_addr),     m_addr);
            chk("imem_wdata",   imem_wdata,         m_wdata);
            chk("words_loaded", 32'(words_loaded),  32'(m_words));
            if (imem_we) begin
                wr_addr.push_back(int'(imem_addr));
                wr_data.push_back(int'(imem_wdata));
                wr_cyc.push_back(cyc);
            end
            if (cpu_start && !start_prev) start_cyc = cyc;
            start_prev = cpu_start;
        end
    end

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_load();
        load_req = 1'b1;
        @(posedge clk); #1;
        load_req = 1'b0;
    endtask

    logic [7:0] frame_b [10] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};

    initial begin
        int base, acc_cyc;
        rst = 1'b1; rx_data = '0; rx_valid = 1'b0; load_req = 1'b0;
        #3 rst = 1'b0;
        chk_on = 1'b1;
        @(negedge clk);
        chk("rst_cpu_start", {31'd0, cpu_start}, 32'd0);
        chk("rst_words",     32'(words_loaded),  32'd0);
        @(posedge clk); #1 rst = 1'b1;

        // Reset in the middle of DATA
        send(8'h02); send(8'h00);
        send(8'hA1); send(8'hA2); send(8'hA3); send(8'hA4); send(8'hA5);
        rx_valid = 1'b0;
        #2 rst = 1'b0;
        @(negedge clk);
        chk("arst_we",    {31'd0, imem_we},   32'd0);
        chk("arst_addr",  32'(imem_addr),     32'd0);
        chk("arst_wdata", imem_wdata,         32'd0);
        chk("arst_words", 32'(words_loaded),  32'd0);
        chk("arst_err",   {31'd0, error},     32'd0);
        chk("arst_busy",  {31'd0, busy},      32'd1);
        @(posedge clk); #1 rst = 1'b1;

        // Two-word frame, back-to-back
        base = wr_addr.size();
        for (int i = 0; i < 10; i++) send(frame_b[i]);
        idle(3);
        chk("b_nwr",    32'(wr_addr.size() - base), 32'd2);
        if (wr_addr.size() >= base + 2) begin
            chk("b_a0",    32'(wr_addr[base]),     32'd0);
            chk("b_d0",    32'(wr_data[base]),     32'h00100513);
            chk("b_a1",    32'(wr_addr[base + 1]), 32'd1);
            chk("b_d1",    32'(wr_data[base + 1]), 32'h00200593);
            chk("b_gap",   32'(wr_cyc[base + 1] - wr_cyc[base]), 32'd4);
            chk("b_start", 32'(start_cyc), 32'(wr_cyc[base + 1] + 1));
        end
        chk("b_words", 32'(words_loaded), 32'd2);
        chk("b_run",   {31'd0, cpu_start}, 32'd1);

        // load_req in RUN with a byte offered in the same cycle
        rx_data = 8'hAA; rx_valid = 1'b1; load_req = 1'b1;
        @(posedge clk); #1;
        load_req = 1'b0; rx_valid = 1'b0;
        chk("f_start", {31'd0, cpu_start}, 32'd0);
        chk("f_busy",  {31'd0, busy},      32'd1);
        base = wr_addr.size();
        send(8'h01); send(8'h00); send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
        idle(3);
        chk("f_nwr", 32'(wr_addr.size() - base), 32'd1);
        if (wr_addr.size() > base) begin
            chk("f_a0", 32'(wr_addr[base]), 32'd0);
            chk("f_d0", 32'(wr_data[base]), 32'hDEADBEEF);
        end

        // Empty program
        pulse_load();
        base = wr_addr.size();
        send(8'h00);
        send(8'h00);
        acc_cyc = cyc;
        idle(4);
        chk("c_nwr",   32'(wr_addr.size() - base), 32'd0);
        chk("c_start", 32'(start_cyc), 32'(acc_cyc + 1));
        chk("c_words", 32'(words_loaded), 32'd0);

        // Oversized count
        pulse_load();
        send(8'h01); send(8'h01);
        chk("d_err",   {31'd0, error},     32'd1);
        chk("d_start", {31'd0, cpu_start}, 32'd0);
        chk("d_rdy",   {31'd0, rx_ready},  32'd0);
        send(8'h55);
        idle(2);
        pulse_load();
        chk("d_clr_err", {31'd0, error}, 32'd0);
        chk("d_busy",    {31'd0, busy},  32'd1);

        // Gap timeout mid-word
        base = wr_addr.size();
        send(8'h01); send(8'h00); send(8'h11); send(8'h22);
        idle(15);
        chk("e_pre",  {31'd0, error}, 32'd0);
        idle(1);
        chk("e_err",  {31'd0, error}, 32'd1);
        chk("e_nwr",  32'(wr_addr.size() - base), 32'd0);
        idle(3);
        pulse_load();
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
